// File: rtl/proc_pkg.sv
// Shared types and constants for the multi-cycle processor controller.
package proc_pkg;

    // Instruction opcodes held in IR[15:12]; A..F are undefined.
    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5,
        OP_JZ    = 4'h6,
        OP_COPY  = 4'h7,
        OP_INC   = 4'h8,
        OP_JMP   = 4'h9
    } opcode_e;

    // Controller states; the encoding is visible on the State debug port.
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_EXEC   = 4'd7,
        S_HALT   = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    // ALU operation selects.
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_INC  = 3'd2;
    localparam logic [2:0] ALU_COPY = 3'd3;
    localparam logic [2:0] ALU_NONE = 3'd7;

    // IR field positions.
    localparam int IR_OP_MSB = 15;
    localparam int IR_OP_LSB = 12;
    localparam int IR_RA_MSB = 11;
    localparam int IR_RA_LSB = 8;
    localparam int IR_RB_MSB = 7;
    localparam int IR_RB_LSB = 4;
    localparam int IR_W_MSB  = 3;
    localparam int IR_W_LSB  = 0;
    localparam int IR_LD_MSB = 11;  // load address IR[11:4]
    localparam int IR_LD_LSB = 4;
    localparam int IR_ST_MSB = 7;   // store address / JZ target IR[7:0]
    localparam int IR_ST_LSB = 0;

    // ALU select for the register-to-register group.
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_INC:  return ALU_INC;
            OP_COPY: return ALU_COPY;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/proc_pc_reg.sv
// Program counter register: clear beats load beats increment; wraps at 2^PC_W.
module proc_pc_reg #(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            clr,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    // Prioritised PC update.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     pc <= '0;
        else if (clr)  pc <= '0;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle controller: owns PC and IR, sequences fetch/decode/execute,
// guards every handshake state with a watchdog.
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int PC_W       = 7,
    parameter int WAIT_LIMIT = 15
) (
    input  logic            Clock,
    input  logic            Reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     IR,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    input  logic            dmem_ready,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0,
    input  logic            alu_zero,
    output logic            halted,
    output logic            illegal_op,
    output logic            timeout,
    output logic [3:0]      State
);

    // Last watchdog count at which a pending handshake is still allowed to complete.
    localparam logic [7:0] WD_LAST = 8'(WAIT_LIMIT - 1);

    state_e          state;
    logic [15:0]     ir;
    logic [7:0]      wait_cnt;
    logic [PC_W-1:0] pc;
    logic            pc_clr, pc_inc, pc_load;
    logic [PC_W-1:0] pc_load_val;
    logic [11:0]     jmp_tgt;
    logic [3:0]      op;
    logic            wd_expired;

    assign op         = ir[IR_OP_MSB:IR_OP_LSB];
    assign wd_expired = (wait_cnt >= WD_LAST);
    assign IR         = ir;
    assign State      = state;
    assign imem_addr  = pc;

    // JZ takes the 8-bit field, JMP the 12-bit field; both resize to PC_W.
    assign jmp_tgt     = (op == OP_JZ) ? {4'b0, ir[IR_ST_MSB:IR_ST_LSB]} : ir[11:0];
    assign pc_load_val = PC_W'(jmp_tgt);

    proc_pc_reg #(.PC_W(PC_W)) u_pc (
        .Clock    (Clock),
        .Reset    (Reset),
        .clr      (pc_clr),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    // State sequencing, IR capture, watchdog count and sticky timeout.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_INIT;
            ir       <= '0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= '0;  // any state change restarts the watchdog
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        state <= S_DECODE;
                    end else if (wd_expired) begin
                        timeout <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_NOOP:                         state <= S_NOOP;
                        OP_STORE:                        state <= S_STORE;
                        OP_LOAD:                         state <= S_LOAD_A;
                        OP_ADD, OP_SUB, OP_COPY, OP_INC: state <= S_EXEC;
                        OP_HALT:                         state <= S_HALT;
                        OP_JZ, OP_JMP:                   state <= S_BRANCH;
                        default:                         state <= S_FETCH;
                    endcase
                end
                S_LOAD_A: begin
                    if (dmem_ready) begin
                        state <= S_LOAD_B;
                    end else if (wd_expired) begin
                        timeout <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_STORE: begin
                    if (dmem_ready) begin
                        state <= S_FETCH;
                    end else if (wd_expired) begin
                        timeout <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_NOOP, S_LOAD_B, S_EXEC, S_BRANCH: state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    // Output decode from the current state and IR; everything idle by default.
    always_comb begin
        imem_req    = 1'b0;
        D_addr      = '0;
        D_rd        = 1'b0;
        D_wr        = 1'b0;
        RF_s        = 1'b0;
        RF_W_en     = 1'b0;
        RF_W_addr   = '0;
        RF_Ra_addr  = '0;
        RF_Rb_addr  = '0;
        Alu_s0      = ALU_NONE;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        pc_clr      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        case (state)
            S_INIT:  pc_clr   = 1'b1;
            S_FETCH: imem_req = 1'b1;
            S_DECODE: begin
                if (op <= OP_JMP) pc_inc     = 1'b1;
                else              illegal_op = 1'b1;
            end
            S_LOAD_A: begin
                D_addr    = ir[IR_LD_MSB:IR_LD_LSB];
                D_rd      = 1'b1;
                RF_s      = 1'b1;
                RF_W_addr = ir[IR_W_MSB:IR_W_LSB];
            end
            S_LOAD_B: begin
                D_addr    = ir[IR_LD_MSB:IR_LD_LSB];
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_addr = ir[IR_W_MSB:IR_W_LSB];
            end
            S_STORE: begin
                D_addr     = ir[IR_ST_MSB:IR_ST_LSB];
                D_wr       = 1'b1;
                RF_Ra_addr = ir[IR_RA_MSB:IR_RA_LSB];
            end
            S_EXEC: begin
                RF_Ra_addr = ir[IR_RA_MSB:IR_RA_LSB];
                RF_Rb_addr = ir[IR_RB_MSB:IR_RB_LSB];
                RF_W_addr  = ir[IR_W_MSB:IR_W_LSB];
                RF_W_en    = 1'b1;
                Alu_s0     = alu_sel(op);
            end
            S_BRANCH: begin
                if (op == OP_JZ) begin
                    RF_Ra_addr = ir[IR_RA_MSB:IR_RA_LSB];
                    Alu_s0     = ALU_COPY;
                    pc_load    = alu_zero;
                end else begin
                    pc_load = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit with an instruction-level reference model.
module tb_proc_control_unit;

    localparam int PC_W       = 7;
    localparam int WAIT_LIMIT = 15;
    localparam int MEMSZ      = 1 << PC_W;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req, imem_ack;
    logic [15:0]     imem_data, IR;
    logic [7:0]      D_addr;
    logic            D_rd, D_wr, dmem_ready;
    logic            RF_s, RF_W_en;
    logic [3:0]      RF_W_addr, RF_Ra_addr, RF_Rb_addr;
    logic [2:0]      Alu_s0;
    logic            alu_zero = 1'b0;
    logic            halted, illegal_op, timeout;
    logic [3:0]      State;

    int tests = 0;
    int fails = 0;

    logic [15:0] imem [0:MEMSZ-1];
    int imem_delay = 0;
    int dmem_delay = 0;
    int icnt = 0;
    int dcnt = 0;

    proc_control_unit #(.PC_W(PC_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .IR(IR), .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .dmem_ready(dmem_ready),
        .RF_s(RF_s), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0),
        .alu_zero(alu_zero), .halted(halted), .illegal_op(illegal_op),
        .timeout(timeout), .State(State)
    );

    always #5 Clock = ~Clock;

    // Memories answer after a programmable number of waiting cycles.
    assign imem_data  = imem[imem_addr];
    assign imem_ack   = imem_req && (icnt >= imem_delay);
    assign dmem_ready = (D_rd || D_wr) && (dcnt >= dmem_delay);

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= ((D_rd || D_wr) && !dmem_ready) ? dcnt + 1 : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct { bit ld; int w; int dad; int alu; int ra; int rb; } wr_t;
    typedef struct { int dad; int ra; } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  fetch_log[$];
    int  mpc = 0;
    bit  ill_pend = 1'b0;

    // Architectural effect of one fetched instruction.
    task automatic model_exec(input logic [15:0] ins);
        int  op, a, b, w;
        wr_t e;
        st_t s;
        op = int'(ins[15:12]);
        a  = int'(ins[11:8]);
        b  = int'(ins[7:4]);
        w  = int'(ins[3:0]);
        case (op)
            1: begin
                s.dad = int'(ins[7:0]); s.ra = a;
                sq.push_back(s);
                mpc = (mpc + 1) % MEMSZ;
            end
            2: begin
                e.ld = 1'b1; e.w = w; e.dad = int'(ins[11:4]); e.alu = 0; e.ra = 0; e.rb = 0;
                wq.push_back(e);
                mpc = (mpc + 1) % MEMSZ;
            end
            3, 4, 7, 8: begin
                e.ld = 1'b0; e.w = w; e.dad = 0; e.ra = a; e.rb = b;
                e.alu = (op == 3) ? 0 : (op == 4) ? 1 : (op == 8) ? 2 : 3;
                wq.push_back(e);
                mpc = (mpc + 1) % MEMSZ;
            end
            6:       mpc = alu_zero ? int'(ins[7:0]) % MEMSZ : (mpc + 1) % MEMSZ;
            9:       mpc = int'(ins[11:0]) % MEMSZ;
            0, 5:    mpc = (mpc + 1) % MEMSZ;
            default: ill_pend = 1'b1;
        endcase
    endtask

    // Cycle compare against the model.
    always @(negedge Clock) begin
        wr_t e;
        if (Reset) begin
            wq.delete(); sq.delete(); mpc = 0; ill_pend = 1'b0;
        end else begin
            chk("illegal_op", illegal_op, ill_pend);
            ill_pend = 1'b0;
            chk("rd_wr_exclusive", D_rd && D_wr, 0);
            if (halted) chk("halt_quiet", {imem_req, D_rd, D_wr, RF_W_en}, 0);
            if (RF_W_en) begin
                chk("write_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", RF_W_addr, e.w);
                    chk("wr_sel", RF_s, e.ld);
                    if (e.ld) chk("ld_daddr", D_addr, e.dad);
                    else begin
                        chk("alu_sel", Alu_s0, e.alu);
                        chk("exec_ra", RF_Ra_addr, e.ra);
                        chk("exec_rb", RF_Rb_addr, e.rb);
                    end
                end
            end
            if (D_rd) begin
                chk("read_expected", (wq.size() > 0) && wq[0].ld, 1);
                if (wq.size() > 0) chk("rd_daddr", D_addr, wq[0].dad);
            end
            if (D_wr) begin
                chk("store_expected", sq.size() > 0, 1);
                if (sq.size() > 0) begin
                    chk("st_daddr", D_addr, sq[0].dad);
                    chk("st_ra", RF_Ra_addr, sq[0].ra);
                    if (dmem_ready) void'(sq.pop_front());
                end
            end
            if (imem_req && imem_ack) begin
                fetch_log.push_back(int'(imem_addr));
                chk("fetch_addr", imem_addr, mpc);
                model_exec(imem_data);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < MEMSZ; i++) imem[i] = v;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        chk("rst_state", State, 0);
        chk("rst_ir", IR, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_strobes", {imem_req, D_rd, D_wr, RF_W_en, halted, illegal_op}, 0);
        chk("rst_alu", Alu_s0, 7);
        chk("rst_addr", {imem_addr, D_addr}, 0);
        fetch_log.delete();
        #2 Reset = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int maxc);
        int n;
        n = 0;
        while (!halted && n < maxc) begin
            @(negedge Clock);
            n++;
        end
        chk(name, halted, 1);
    endtask

    logic [3:0] seq1 [0:10] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 4'd8, 4'd8};

    initial begin
        int nw, nwr, n;

        // LOAD / ADD / HALT with zero-wait memories
        fill(16'h5000);
        imem[0] = 16'h2A53; imem[1] = 16'h3531; imem[2] = 16'h5000;
        do_reset();
        nw = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge Clock);
            chk("t1_state", State, seq1[i]);
            if (RF_W_en) nw++;
            if (i == 2) chk("t1_loada", {D_rd, D_addr}, {1'b1, 8'hA5});
            if (i == 3) chk("t1_loadb", {RF_W_en, RF_s, RF_W_addr, D_addr, D_rd}, {1'b1, 1'b1, 4'h3, 8'hA5, 1'b0});
            if (i == 6) chk("t1_add", {Alu_s0, RF_W_addr, RF_Ra_addr, RF_Rb_addr}, {3'd0, 4'h1, 4'h5, 4'h3});
            if (i == 9) chk("t1_halt", {halted, imem_addr}, {1'b1, 7'd3});
        end
        chk("t1_nwrites", nw, 2);
        chk("t1_drained", wq.size(), 0);

        // instruction fetch acknowledged after 3 waiting cycles
        imem_delay = 3;
        fill(16'h5000);
        imem[0] = 16'h3123;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            chk("t2_wait_state", State, 1);
            chk("t2_req", imem_req, 1);
            chk("t2_ir_stable", IR, 0);
            chk("t2_ack", imem_ack, (i == 3) ? 1 : 0);
        end
        @(negedge Clock);
        chk("t2_decode", {State, IR}, {4'd2, 16'h3123});
        wait_halt("t2_halt", 40);
        chk("t2_pc", imem_addr, 2);
        imem_delay = 0;

        // JZ taken
        alu_zero = 1'b1;
        fill(16'h5000);
        imem[0] = 16'h6205;
        do_reset();
        wait_halt("t3a_halt", 30);
        chk("t3a_nfetch", fetch_log.size(), 2);
        if (fetch_log.size() == 2) chk("t3a_target", fetch_log[1], 5);
        chk("t3a_pc", imem_addr, 6);

        // JZ not taken
        alu_zero = 1'b0;
        do_reset();
        wait_halt("t3b_halt", 30);
        chk("t3b_nfetch", fetch_log.size(), 2);
        if (fetch_log.size() == 2) chk("t3b_target", fetch_log[1], 1);
        chk("t3b_pc", imem_addr, 2);

        // JMP to 0x7F, NOOP there wraps PC to 0
        fill(16'h5000);
        imem[0] = 16'h907F; imem[127] = 16'h0000;
        do_reset();
        repeat (8) @(negedge Clock);
        chk("t4_nfetch", fetch_log.size(), 3);
        if (fetch_log.size() == 3) begin
            chk("t4_jmp", fetch_log[1], 7'h7F);
            chk("t4_wrap", fetch_log[2], 0);
        end
        chk("t4_flags", {timeout, halted}, 0);

        // STORE with data memory never ready: watchdog fires
        dmem_delay = 1000;
        fill(16'h5000);
        imem[0] = 16'h1C37;
        do_reset();
        n = 0; nwr = 0;
        while (!halted && n < 60) begin
            @(negedge Clock);
            n++;
            if (D_wr) nwr++;
        end
        chk("t5_dwr_cycles", nwr, 15);
        chk("t5_timeout", {timeout, halted, State}, {1'b1, 1'b1, 4'd8});

        // STORE with ready in the limit cycle: no timeout
        dmem_delay = 14;
        do_reset();
        n = 0; nwr = 0;
        while (!halted && n < 60) begin
            @(negedge Clock);
            n++;
            if (D_wr) nwr++;
        end
        chk("t5b_dwr_cycles", nwr, 15);
        chk("t5b_timeout", timeout, 0);
        chk("t5b_pc", imem_addr, 2);
        chk("t5b_drained", sq.size(), 0);
        dmem_delay = 0;

        // undefined opcode
        fill(16'h5000);
        imem[0] = 16'hB000;
        do_reset();
        @(negedge Clock);
        chk("t6_fetch", State, 1);
        @(negedge Clock);
        chk("t6_pulse", {State, illegal_op}, {4'd2, 1'b1});
        @(negedge Clock);
        chk("t6_refetch", {State, illegal_op, imem_addr}, {4'd1, 1'b0, 7'd0});

        // asynchronous reset while waiting in LOAD_A
        dmem_delay = 1000;
        imem[0] = 16'h2A53;
        do_reset();
        repeat (3) @(negedge Clock);
        chk("t7_loada", {State, D_rd}, {4'd4, 1'b1});
        #2 Reset = 1'b1;
        #1 chk("t7_async", {State, D_rd, D_wr, RF_W_en, imem_req}, {4'd0, 4'd0});
        dmem_delay = 0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

endmodule
